// File: rtl/v10_pulse_generator.sv
// Synthetic detector-pulse source: linear rise, exponential decay, pile-up aware,
// on a signed ADC-width stream. Define V10_PULSE_GEN_NOISE_EN to add 2-bit LFSR noise.
module v10_pulse_generator #(
  parameter int SIZE_ADC_DATA = 12,
  parameter int DECAY_SHIFT   = 5,
  parameter int RISE_SHIFT    = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            trig,
  input  logic        [SIZE_ADC_DATA-1:0] amplitude,
  input  logic signed [SIZE_ADC_DATA-1:0] baseline,
  output logic signed [SIZE_ADC_DATA-1:0] output_data,
  output logic                            busy,
  output logic                            pulse_start,
  output logic        [7:0]               dropped,
  output logic                            overflow
);

  localparam int IW = SIZE_ADC_DATA + 1;
  localparam int AW = IW + DECAY_SHIFT;
  // Two spare bits over baseline + acc_int so a fully clamped accumulator cannot wrap.
  localparam int SW = SIZE_ADC_DATA + 3;
  localparam int CW = RISE_SHIFT + 1;
  localparam logic [AW-1:0] ACC_MAX = '1;
  localparam logic [CW-1:0] RISE_LEN = CW'(2**RISE_SHIFT);
  localparam int OUT_MAX_I = 2**(SIZE_ADC_DATA-1) - 1;
  localparam logic signed [SW-1:0] OUT_MAX = SW'(OUT_MAX_I);
  localparam logic signed [SW-1:0] OUT_MIN = SW'(-OUT_MAX_I - 1);

  typedef enum logic [1:0] {IDLE, RISE, DECAY} state_t;

  state_t               state, state_p0;
  logic [AW-1:0]        acc, acc_p0, step, step_p0, step_live_p0, base_p0;
  logic [CW-1:0]        rise_cnt, cnt_p0;
  logic [IW-1:0]        acc_int_p0;
  logic                 accept_p0, drop_p0, clamp_p0, clip_p0;
  logic signed [SW-1:0] sum_p0;
  logic signed [SIZE_ADC_DATA-1:0] out_p0;
  logic signed [1:0]    noise;

  // Returns {clamped, value}; the value pins at ACC_MAX when the add carries out.
  function automatic logic [AW:0] acc_add(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s[AW]) return {1'b1, ACC_MAX};
    return s;
  endfunction

  // Returns {clipped, value} saturated to the signed sample range.
  function automatic logic [SIZE_ADC_DATA:0] sat_out(input logic signed [SW-1:0] s);
    if (s > OUT_MAX) return {1'b1, 1'b0, {(SIZE_ADC_DATA-1){1'b1}}};
    if (s < OUT_MIN) return {1'b1, 1'b1, {(SIZE_ADC_DATA-1){1'b0}}};
    return {1'b0, s[SIZE_ADC_DATA-1:0]};
  endfunction

`ifdef V10_PULSE_GEN_NOISE_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end
  assign noise = $signed(lfsr[1:0]);
`else
  assign noise = '0;
`endif

  assign step_live_p0 = (AW'(amplitude) << DECAY_SHIFT) >> RISE_SHIFT;

  // ---- stage p0: next accumulator / state and saturated output sample ----
  always_comb begin
    state_p0  = state;
    acc_p0    = acc;
    step_p0   = step;
    cnt_p0    = rise_cnt;
    base_p0   = acc;
    accept_p0 = 1'b0;
    drop_p0   = 1'b0;
    clamp_p0  = 1'b0;
    case (state)
      IDLE: begin
        acc_p0 = '0;
        if (trig) begin
          accept_p0           = 1'b1;
          {clamp_p0, acc_p0}  = acc_add('0, step_live_p0);
          step_p0             = step_live_p0;
          cnt_p0              = CW'(1);
          state_p0            = (RISE_SHIFT == 0) ? DECAY : RISE;
        end
      end
      RISE: begin
        {clamp_p0, acc_p0} = acc_add(acc, step);
        cnt_p0             = rise_cnt + CW'(1);
        if (cnt_p0 == RISE_LEN) state_p0 = DECAY;
        drop_p0            = trig;
      end
      DECAY: begin
        if (trig) begin
          // A tail that has already reached zero restarts from an empty accumulator.
          base_p0            = (acc[AW-1:DECAY_SHIFT] == '0) ? '0 : acc;
          accept_p0          = 1'b1;
          {clamp_p0, acc_p0} = acc_add(base_p0, step_live_p0);
          step_p0            = step_live_p0;
          cnt_p0             = CW'(1);
          state_p0           = (RISE_SHIFT == 0) ? DECAY : RISE;
        end else if (acc[AW-1:DECAY_SHIFT] == '0) begin
          acc_p0   = '0;
          state_p0 = IDLE;
        end else begin
          acc_p0 = acc - (acc >> DECAY_SHIFT);
        end
      end
      default: begin
        acc_p0   = '0;
        state_p0 = IDLE;
      end
    endcase
  end

  assign acc_int_p0        = acc_p0[AW-1:DECAY_SHIFT];
  assign sum_p0            = SW'(baseline) + $signed(SW'(acc_int_p0)) + SW'(noise);
  assign {clip_p0, out_p0} = sat_out(sum_p0);

  // ---- stage p1: registered state and outputs ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      step        <= '0;
      rise_cnt    <= '0;
      output_data <= '0;
      busy        <= 1'b0;
      pulse_start <= 1'b0;
      dropped     <= '0;
      overflow    <= 1'b0;
    end else begin
      state       <= state_p0;
      acc         <= acc_p0;
      step        <= step_p0;
      rise_cnt    <= cnt_p0;
      output_data <= out_p0;
      busy        <= (state_p0 != IDLE);
      pulse_start <= accept_p0;
      if (drop_p0 && dropped != 8'hFF) dropped <= dropped + 8'd1;
      if (clamp_p0 || clip_p0)         overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_v10_pulse_generator.sv
// Directed bench for v10_pulse_generator: default-parameter instance plus a
// RISE_SHIFT=0 instance for step mode; expected samples are hand-computed.
module tb_v10_pulse_generator;
  localparam int W = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset, trig, trig_s;
  logic        [W-1:0] amplitude, amp_s;
  logic signed [W-1:0] baseline, base_s;
  logic signed [W-1:0] output_data, out_s;
  logic                busy, busy_s, pulse_start, ps_s, overflow, ovf_s;
  logic        [7:0]   dropped, dropped_s;

  int checks   = 0;
  int failures = 0;

  v10_pulse_generator u_dut (
    .clk(clk), .reset(reset), .trig(trig), .amplitude(amplitude), .baseline(baseline),
    .output_data(output_data), .busy(busy), .pulse_start(pulse_start),
    .dropped(dropped), .overflow(overflow)
  );

  v10_pulse_generator #(.SIZE_ADC_DATA(12), .DECAY_SHIFT(5), .RISE_SHIFT(0)) u_step (
    .clk(clk), .reset(reset), .trig(trig_s), .amplitude(amp_s), .baseline(base_s),
    .output_data(out_s), .busy(busy_s), .pulse_start(ps_s),
    .dropped(dropped_s), .overflow(ovf_s)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; trig = 1'b0; trig_s = 1'b0;
    amplitude = '0; baseline = 12'sd100; amp_s = '0; base_s = '0;
    tick; tick;
    checks++;
    if (output_data !== 0 || busy !== 0 || pulse_start !== 0 || dropped !== 0 || overflow !== 0) begin
      failures++;
      $display("FAIL reset_state out=%0d busy=%b ps=%b dropped=%0d ovf=%b required 0/0/0/0/0",
               output_data, busy, pulse_start, dropped, overflow);
    end
    reset = 1'b0;
    tick;
    checks++;
    if (output_data !== 100) begin
      failures++; $display("FAIL reset_first_edge out=%0d required 100", output_data);
    end
    baseline = -12'sd5;
    tick;
    checks++;
    if (output_data !== -5) begin
      failures++; $display("FAIL baseline_live out=%0d required -5", output_data);
    end
    baseline = 12'sd100;
    tick;
  endtask

  task automatic test_basic;
    int exp_b[5];
    int n;
    exp_b = '{200, 300, 400, 500, 487};
    amplitude = 12'd400; baseline = 12'sd100;
    trig = 1'b1;
    tick;
    trig = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick;
      checks++;
      if (output_data !== exp_b[i]) begin
        failures++; $display("FAIL basic_edge%0d out=%0d required %0d", i + 1, output_data, exp_b[i]);
      end
      if (i < 2) begin
        checks++;
        if (pulse_start !== (i == 0) || busy !== 1'b1) begin
          failures++;
          $display("FAIL basic_flags_edge%0d ps=%b busy=%b required %b/1", i + 1, pulse_start, busy, i == 0);
        end
      end
    end
    n = 0;
    while (busy === 1'b1 && n < 2000) begin tick; n++; end
    checks++;
    if (busy !== 1'b0 || output_data !== 100) begin
      failures++; $display("FAIL basic_tail busy=%b out=%0d required 0/100", busy, output_data);
    end
    checks++;
    if (overflow !== 1'b0 || dropped !== 8'd0) begin
      failures++; $display("FAIL basic_flags ovf=%b dropped=%0d required 0/0", overflow, dropped);
    end
  endtask

  task automatic test_dropped;
    int n;
    trig = 1'b1;
    tick;
    checks++;
    if (output_data !== 200) begin
      failures++; $display("FAIL drop_edge1 out=%0d required 200", output_data);
    end
    tick;
    trig = 1'b0;
    checks++;
    if (output_data !== 300 || dropped !== 8'd1 || pulse_start !== 1'b0) begin
      failures++;
      $display("FAIL drop_edge2 out=%0d dropped=%0d ps=%b required 300/1/0", output_data, dropped, pulse_start);
    end
    tick; tick;
    checks++;
    if (output_data !== 500) begin
      failures++; $display("FAIL drop_peak out=%0d required 500", output_data);
    end
    n = 0;
    while (busy === 1'b1 && n < 2000) begin tick; n++; end
    checks++;
    if (busy !== 1'b0 || dropped !== 8'd1) begin
      failures++; $display("FAIL drop_end busy=%b dropped=%0d required 0/1", busy, dropped);
    end
  endtask

  task automatic test_pileup;
    int exp_p[5];
    int n;
    int ps_cnt;
    exp_p = '{500, 600, 700, 800, 778};
    trig = 1'b1;
    tick;
    trig = 1'b0;
    ps_cnt = int'(pulse_start);
    for (int e = 2; e <= 13; e++) begin
      tick;
      ps_cnt += int'(pulse_start);
      if (e == 4) begin
        checks++;
        if (output_data !== 500) begin
          failures++; $display("FAIL pile_first_peak out=%0d required 500", output_data);
        end
      end
    end
    checks++;
    if (output_data !== 400) begin
      failures++; $display("FAIL pile_decayed out=%0d required 400", output_data);
    end
    trig = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      trig = 1'b0;
      ps_cnt += int'(pulse_start);
      checks++;
      if (output_data !== exp_p[i]) begin
        failures++; $display("FAIL pile_edge%0d out=%0d required %0d", 14 + i, output_data, exp_p[i]);
      end
    end
    checks++;
    if (ps_cnt !== 2) begin
      failures++; $display("FAIL pile_pulse_start count=%0d required 2", ps_cnt);
    end
    n = 0;
    while (busy === 1'b1 && n < 2000) begin tick; n++; end
    checks++;
    if (busy !== 1'b0 || output_data !== 100 || dropped !== 8'd1) begin
      failures++;
      $display("FAIL pile_end busy=%b out=%0d dropped=%0d required 0/100/1", busy, output_data, dropped);
    end
  endtask

  task automatic test_clip;
    int n;
    baseline = 12'sd2000; amplitude = 12'd4000;
    trig = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      tick;
      trig = 1'b0;
      checks++;
      if (output_data !== 2047 || overflow !== 1'b1) begin
        failures++; $display("FAIL clip_edge%0d out=%0d ovf=%b required 2047/1", e, output_data, overflow);
      end
    end
    n = 0;
    while (busy === 1'b1 && n < 3000) begin tick; n++; end
    checks++;
    if (busy !== 1'b0 || output_data !== 2000 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL clip_sticky busy=%b out=%0d ovf=%b required 0/2000/1", busy, output_data, overflow);
    end
  endtask

  task automatic test_reset_mid;
    baseline = 12'sd100; amplitude = 12'd400;
    tick;
    trig = 1'b1;
    tick;
    trig = 1'b0;
    tick; tick;
    checks++;
    if (output_data !== 400) begin
      failures++; $display("FAIL rmid_edge3 out=%0d required 400", output_data);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (output_data !== 0 || busy !== 0 || overflow !== 0 || dropped !== 0 || u_dut.acc !== '0) begin
      failures++;
      $display("FAIL rmid_async out=%0d busy=%b ovf=%b dropped=%0d acc=%0d required all 0",
               output_data, busy, overflow, dropped, u_dut.acc);
    end
    tick;
    reset = 1'b0;
    tick;
    checks++;
    if (output_data !== 100 || busy !== 1'b0) begin
      failures++; $display("FAIL rmid_release out=%0d busy=%b required 100/0", output_data, busy);
    end
  endtask

  task automatic test_step;
    int exp_s[3];
    int n;
    exp_s = '{64, 62, 60};
    base_s = '0; amp_s = 12'd64;
    trig_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      trig_s = 1'b0;
      checks++;
      if (out_s !== exp_s[i] || busy_s !== 1'b1 || ps_s !== (i == 0)) begin
        failures++;
        $display("FAIL step_edge%0d out=%0d busy=%b ps=%b required %0d/1/%b",
                 i + 1, out_s, busy_s, ps_s, exp_s[i], i == 0);
      end
    end
    n = 0;
    while (busy_s === 1'b1 && n < 2000) begin tick; n++; end
    checks++;
    if (busy_s !== 1'b0 || out_s !== 0 || ovf_s !== 1'b0) begin
      failures++; $display("FAIL step_end busy=%b out=%0d ovf=%b required 0/0/0", busy_s, out_s, ovf_s);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_dropped;
    test_pileup;
    test_clip;
    test_reset_mid;
    test_step;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
